// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock with a start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port and a - b support (a + ~b + 1).
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             sub_eff;
    logic [WIDTH-1:0] b_eff;
    logic [DIGIT:0]   digit_full;
    logic [WIDTH-1:0] digit_top;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    assign b_eff = sub_eff ? ~b : b;

    // One digit of the ripple: low digits of both shift registers plus the carry flop.
    assign digit_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign digit_top  = WIDTH'(digit_full[DIGIT-1:0]) << (WIDTH - DIGIT);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = sub_eff;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end

            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_full[DIGIT];
                res_d   = (res_q >> DIGIT) | digit_top;
                cnt_d   = cnt_q + CW'(1);
                // Published outputs move only here, so partial sums never appear on sum.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    c_out_d = digit_full[DIGIT];
                    ovf_d   = (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three 8-bit instances (DIGIT 2, 1, 8) share stimulus; table vectors,
// hand-written handshake/abort sequences and random operands checked against an arithmetic model.
module tb_serial_adder;

    localparam int W = 8;
    localparam int NS[3] = '{4, 8, 1};

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    logic         busy_w [3];
    logic         done_w [3];
    logic         cout_w [3];
    logic         ovf_w  [3];
    logic [W-1:0] sum_w  [3];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .c_out(cout_w[0]), .overflow(ovf_w[0])
    );

    serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .c_out(cout_w[1]), .overflow(ovf_w[1])
    );

    serial_adder #(.WIDTH(W), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .c_out(cout_w[2]), .overflow(ovf_w[2])
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        string        name;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        res_t r;
        int ux = int'(x);
        int uy = int'(y);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int ur = s ? ux - uy : ux + uy;
        int sr = s ? sx - sy : sx + sy;
        r.sum  = W'(ur);
        r.cout = s ? (ux >= uy) : (ur > 255);
        r.ovf  = (sr > 127) || (sr < -128);
        return r;
    endfunction

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One operation on all three instances: checks busy window, latency, single done pulse, results.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input logic [W-1:0] esum, input logic ecout, input logic eovf,
                         input string name);
        int lat[3];
        int dn[3];
        lat = '{-1, -1, -1};
        dn  = '{0, 0, 0};
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        sub   = ts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = W'($urandom);
        sub   = ~ts;
        for (int k = 0; k < 12; k++) begin
            if (k <= 4) check($sformatf("%s busy k%0d", name, k), 32'(busy_w[0]), 32'(k < 4));
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    dn[i]++;
                    if (lat[i] < 0) lat[i] = k;
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s n%0d latency", name, NS[i]), 32'(lat[i]), 32'(NS[i]));
            check($sformatf("%s n%0d done_pulses", name, NS[i]), 32'(dn[i]), 32'd1);
            check($sformatf("%s n%0d sum", name, NS[i]), 32'(sum_w[i]), 32'(esum));
            check($sformatf("%s n%0d c_out", name, NS[i]), 32'(cout_w[i]), 32'(ecout));
            check($sformatf("%s n%0d overflow", name, NS[i]), 32'(ovf_w[i]), 32'(eovf));
        end
    endtask

    initial begin
        res_t r;
        logic [W-1:0] ra, rb;
        logic rs;

        vecs.push_back('{8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, "add_3c_45"});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap_ff_01"});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "wrap_80_80"});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_7f_01"});
        vecs.push_back('{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "add_01_02"});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero"});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07"});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, "sub_07_05"});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01"});
`endif

        // Reset: outputs zero, start ignored while rst_n is low.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst n%0d busy", NS[i]), 32'(busy_w[i]), 32'd0);
            check($sformatf("rst n%0d done", NS[i]), 32'(done_w[i]), 32'd0);
            check($sformatf("rst n%0d sum", NS[i]), 32'(sum_w[i]), 32'd0);
            check($sformatf("rst n%0d c_out", NS[i]), 32'(cout_w[i]), 32'd0);
            check($sformatf("rst n%0d overflow", NS[i]), 32'(ovf_w[i]), 32'd0);
        end
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        @(negedge clk);
        check("rst start_ignored", 32'(busy_w[0]), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst release_idle", 32'(busy_w[0]), 32'd0);

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].name);

        // Handshake: start held high gives done every N+1 cycles; mid-run operand changes are ignored.
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            check($sformatf("b2b done k%0d", k), 32'(done_w[0]), 32'((k % 5) == 4));
            if ((k % 5) == 4) check($sformatf("b2b sum k%0d", k), 32'(sum_w[0]), 32'h03);
            if ((k % 5) == 1) begin a = 8'h55; b = 8'hAA; end
            if ((k % 5) == 3) begin a = 8'h01; b = 8'h02; end
            @(negedge clk);
        end
        start = 1'b0;
        reset_all();

        // Abort: reset in the second RUN cycle discards the operation.
        do_op(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, "pre_abort");
        @(negedge clk);
        a = 8'hFF;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy_w[0]), 32'd0);
        check("abort done", 32'(done_w[0]), 32'd0);
        check("abort sum", 32'(sum_w[0]), 32'd0);
        check("abort c_out", 32'(cout_w[0]), 32'd0);
        check("abort overflow", 32'(ovf_w[0]), 32'd0);
        @(negedge clk);
        check("abort start_in_reset", 32'(busy_w[0]), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        begin
            int late_done = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (done_w[0]) late_done++;
            end
            check("abort no_done", 32'(late_done), 32'd0);
        end
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "post_abort");

        // Random operands against the arithmetic model.
        for (int n = 0; n < 100; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rs);
            do_op(ra, rb, rs, r.sum, r.cout, r.ovf, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
